// File: rtl/slp_train_ctrl_if.sv
// Labelled-sample stream into the perceptron training sequencer.
// The source is the master; the controller (slp_train_ctrl) is the slave.
interface slp_train_ctrl_if #(
  parameter int IN     = 8,
  parameter int I_PREC = 8,
  parameter int P_PREC = 8
) ();
  // valid/ready: a sample transfers on a rising edge where smp_valid and
  // smp_ready are both high. The source holds smp_valid and its data until
  // that edge. smp_ready never depends combinationally on smp_valid.
  logic                           smp_valid;
  logic                           smp_ready;
  logic [IN-1:0][I_PREC-1:0]      smp_in;
  logic [P_PREC-1:0]              smp_train;

  modport master (output smp_valid, output smp_in, output smp_train, input smp_ready);
  modport slave  (input smp_valid, input smp_in, input smp_train, output smp_ready);
endinterface

// File: rtl/slp_train_ctrl.sv
// Single-layer perceptron training sequencer: owns the weights, fetches samples,
// waits INFER_LAT cycles, then commits slp_train's update. Early stop: SLP_TRAIN_EARLY_STOP_EN.
module slp_train_ctrl #(
  parameter int IN        = 8,
  parameter int I_PREC    = 8,
  parameter int W_PREC    = 8,
  parameter int P_PREC    = 8,
  parameter int SAMPLES   = 16,
  parameter int EPOCHS    = 8,
  parameter int INFER_LAT = 1,
  localparam int WEIGHT   = IN + 1,
  localparam int EW       = $clog2(EPOCHS + 1),
  localparam int SW       = $clog2(SAMPLES + 1)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [WEIGHT-1:0][W_PREC-1:0]   init_weight,
  slp_train_ctrl_if.slave                 smp,
  output logic [IN-1:0][I_PREC-1:0]       dp_in,
  output logic [P_PREC-1:0]               dp_train,
  output logic [WEIGHT-1:0][W_PREC-1:0]   dp_weight,
  input  logic [P_PREC-1:0]               dp_infer,
  input  logic [WEIGHT-1:0][W_PREC-1:0]   dp_new_weight,
  output logic                            busy,
  output logic                            done,
  output logic [EW-1:0]                   epoch_cnt,
  output logic [SW-1:0]                   err_cnt,
  output logic                            converged,
  output logic [2:0]                      dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_INFER  = 3'd2;
  localparam logic [2:0] S_UPDATE = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int LW = (INFER_LAT > 1) ? $clog2(INFER_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT   = LW'(INFER_LAT - 1);
  localparam logic [SW-1:0] SMP_LAST   = SW'(SAMPLES - 1);
  localparam logic [EW-1:0] EPOCH_LAST = EW'(EPOCHS - 1);

  logic [2:0]    state;
  logic [SW-1:0] smp_cnt;
  logic [LW-1:0] lat_cnt;
  logic          start_ok;
  logic          epoch_end;
  logic          early_stop;

  assign start_ok  = start && ((state == S_IDLE) || (state == S_DONE));
  assign epoch_end = (state == S_UPDATE) && (smp_cnt == SMP_LAST);

  assign smp.smp_ready = (state == S_FETCH);
  assign busy          = (state == S_FETCH) || (state == S_INFER) || (state == S_UPDATE);
  assign done          = (state == S_DONE);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      smp_cnt   <= '0;
      lat_cnt   <= '0;
      epoch_cnt <= '0;
      dp_in     <= '0;
      dp_train  <= '0;
      dp_weight <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start_ok) begin
            dp_weight <= init_weight;
            smp_cnt   <= '0;
            lat_cnt   <= '0;
            epoch_cnt <= '0;
            state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (smp.smp_valid) begin
            dp_in    <= smp.smp_in;
            dp_train <= smp.smp_train;
            lat_cnt  <= LAT_INIT;
            state    <= S_INFER;
          end
        end
        S_INFER: begin
          if (lat_cnt == '0) state <= S_UPDATE;
          else               lat_cnt <= lat_cnt - 1'b1;
        end
        S_UPDATE: begin
          dp_weight <= dp_new_weight;
          if (smp_cnt == SMP_LAST) begin
            smp_cnt   <= '0;
            epoch_cnt <= epoch_cnt + 1'b1;
            state     <= ((epoch_cnt == EPOCH_LAST) || early_stop) ? S_DONE : S_FETCH;
          end else begin
            smp_cnt <= smp_cnt + 1'b1;
            state   <= S_FETCH;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SLP_TRAIN_EARLY_STOP_EN
  // err_total includes the sample being retired this cycle.
  logic [SW-1:0] run_err;
  logic [SW-1:0] err_total;
  logic          mispredict;

  assign mispredict = (dp_infer != dp_train);
  assign err_total  = run_err + SW'(mispredict);
  assign early_stop = (err_total == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      run_err   <= '0;
      err_cnt   <= '0;
      converged <= 1'b0;
    end else if (start_ok) begin
      run_err   <= '0;
      err_cnt   <= '0;
      converged <= 1'b0;
    end else if (state == S_UPDATE) begin
      if (epoch_end) begin
        err_cnt   <= err_total;
        run_err   <= '0;
        converged <= (err_total == '0);
      end else begin
        run_err <= err_total;
      end
    end
  end
`else
  logic unused_infer;
  assign unused_infer = ^{dp_infer, epoch_end};
  assign early_stop   = 1'b0;
  assign err_cnt      = '0;
  assign converged    = 1'b0;
`endif

endmodule

// File: tb/tb_slp_train_ctrl.sv
// Directed bench for slp_train_ctrl: timing, weight commits, backpressure, ignored start,
// reset mid-INFER, and (with SLP_TRAIN_EARLY_STOP_EN) error counting and early stop.
module tb_slp_train_ctrl;
  localparam int IN = 2, I_PREC = 8, W_PREC = 8, P_PREC = 8;
  localparam int SAMPLES = 4, EPOCHS = 3, INFER_LAT = 2;
  localparam int WEIGHT = IN + 1;
  localparam int EW = $clog2(EPOCHS + 1), SW = $clog2(SAMPLES + 1);
  localparam int SB_W = IN * I_PREC + P_PREC;
  localparam int PER_SMP = INFER_LAT + 2;
  localparam int CYC_RUN = 1 + EPOCHS * SAMPLES * PER_SMP;
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_INFER = 3'd2;

  typedef logic [WEIGHT-1:0][W_PREC-1:0] wvec_t;

  // clock / reset
  logic clk, reset, start;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  wvec_t                      init_weight, dp_weight, dp_new_weight, w0, w1, w_bogus;
  logic [IN-1:0][I_PREC-1:0]  dp_in;
  logic [P_PREC-1:0]          dp_train, dp_infer;
  logic                       busy, done, converged;
  logic [EW-1:0]              epoch_cnt;
  logic [SW-1:0]              err_cnt;
  logic [2:0]                 dbg_state;

  slp_train_ctrl_if #(.IN(IN), .I_PREC(I_PREC), .P_PREC(P_PREC)) smp ();

  slp_train_ctrl #(
    .IN(IN), .I_PREC(I_PREC), .W_PREC(W_PREC), .P_PREC(P_PREC),
    .SAMPLES(SAMPLES), .EPOCHS(EPOCHS), .INFER_LAT(INFER_LAT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .init_weight(init_weight),
    .smp(smp.slave),
    .dp_in(dp_in), .dp_train(dp_train), .dp_weight(dp_weight),
    .dp_infer(dp_infer), .dp_new_weight(dp_new_weight),
    .busy(busy), .done(done), .epoch_cnt(epoch_cnt), .err_cnt(err_cnt),
    .converged(converged), .dbg_state(dbg_state)
  );

  // datapath model: update adds 1 per weight, inference optionally disagrees
  bit cur_bad;
  int hs_idx, bad_limit;
  always_comb begin
    for (int i = 0; i < WEIGHT; i++) dp_new_weight[i] = dp_weight[i] + W_PREC'(1);
  end
  assign dp_infer = cur_bad ? (dp_train ^ P_PREC'(1)) : dp_train;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic wvec_t wplus(input wvec_t w, input int n);
    wvec_t r;
    for (int i = 0; i < WEIGHT; i++) r[i] = w[i] + W_PREC'(n);
    return r;
  endfunction

  // scoreboard: accepted sample pushed at the handshake edge, checked on dp_* afterwards
  logic [SB_W-1:0] exp_q[$];
  bit pend;
  always @(posedge clk) begin
    if (!reset && smp.smp_valid && smp.smp_ready) begin
      exp_q.push_back({smp.smp_train, smp.smp_in});
      pend    = 1'b1;
      cur_bad = (hs_idx < bad_limit);
      hs_idx++;
    end
  end
  always @(negedge clk) begin
    logic [SB_W-1:0] e;
    if (pend) begin
      pend = 1'b0;
      e = exp_q.pop_front();
      check("dp_in", dp_in, e[IN*I_PREC-1:0]);
      check("dp_train", dp_train, e[SB_W-1 -: P_PREC]);
    end
  end

  // driver: one full training run, returns cycles from the start edge to done
  task automatic run(input wvec_t w, input int hold_low, input bit ign, input int e1_err,
                     output int cyc);
    bit pulsed = 0, e1_seen = 0;
    @(negedge clk);
    hs_idx = 0;
    init_weight = w;
    start = 1'b1;
    smp.smp_valid = (hold_low == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    for (int k = 0; k < hold_low; k++) begin
      check("bp_ready", smp.smp_ready, 1);
      check("bp_state", dbg_state, S_FETCH);
      @(negedge clk);
      cyc++;
    end
    smp.smp_valid = 1'b1;
    while (!done && cyc < 2000) begin
      for (int i = 0; i < IN; i++) smp.smp_in[i] = I_PREC'($urandom_range(0, 255));
      smp.smp_train = P_PREC'($urandom_range(0, 255));
      if (ign && !pulsed && dbg_state == S_INFER) begin
        start = 1'b1;
        init_weight = w_bogus;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (e1_err >= 0 && !e1_seen && epoch_cnt == EW'(1)) begin
        e1_seen = 1;
        check("e1_err_cnt", err_cnt, e1_err);
        check("e1_busy", busy, 1);
        check("e1_converged", converged, 0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    smp.smp_valid = 1'b0;
    check("run_done", done, 1);
    if (e1_err >= 0) check("e1_reached", e1_seen, 1);
  endtask

  int cyc;
  initial begin
    reset = 1'b1; start = 1'b0; init_weight = '0;
    smp.smp_valid = 1'b0; smp.smp_in = '0; smp.smp_train = '0;
    cur_bad = 0; hs_idx = 0; bad_limit = 0; pend = 0;
    w0[0] = 8'd1;  w0[1] = 8'd2;  w0[2] = 8'd3;
    w1[0] = 8'd40; w1[1] = 8'd90; w1[2] = 8'd250;
    w_bogus = {WEIGHT{8'hAA}};

    // reset state
    repeat (3) @(negedge clk);
    check("rst_state", dbg_state, S_IDLE);
    check("rst_ready", smp.smp_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_conv", converged, 0);
    check("rst_dp_in", dp_in, 0);
    check("rst_dp_train", dp_train, 0);
    check("rst_dp_weight", dp_weight, 0);
    check("rst_epoch", epoch_cnt, 0);
    check("rst_err", err_cnt, 0);
    reset = 1'b0;

    // nominal run, every inference wrong so early stop can never trigger
    bad_limit = 1000;
    run(w0, 0, 0, -1, cyc);
    check("nom_cycles", cyc, CYC_RUN);
    check("nom_weight", dp_weight, wplus(w0, EPOCHS * SAMPLES));
    check("nom_epoch", epoch_cnt, EPOCHS);
`ifdef SLP_TRAIN_EARLY_STOP_EN
    check("nom_err", err_cnt, SAMPLES);
`else
    check("nom_err", err_cnt, 0);
`endif
    check("nom_conv", converged, 0);
    check("nom_busy", busy, 0);
    check("nom_ready", smp.smp_ready, 0);
    @(negedge clk);
    check("done_hold_weight", dp_weight, wplus(w0, EPOCHS * SAMPLES));
    check("done_hold_state", done, 1);

    // backpressure: 5 idle FETCH cycles, restarted from DONE
    run(w1, 5, 0, -1, cyc);
    check("bp_cycles", cyc, CYC_RUN + 5);
    check("bp_weight", dp_weight, wplus(w1, EPOCHS * SAMPLES));

    // start pulsed during INFER must be ignored
    run(w0, 0, 1, -1, cyc);
    check("ign_cycles", cyc, CYC_RUN);
    check("ign_weight", dp_weight, wplus(w0, EPOCHS * SAMPLES));
    check("ign_epoch", epoch_cnt, EPOCHS);

`ifdef SLP_TRAIN_EARLY_STOP_EN
    // early stop after a clean first epoch
    bad_limit = 0;
    run(w1, 0, 0, -1, cyc);
    check("es_cycles", cyc, 1 + SAMPLES * PER_SMP);
    check("es_conv", converged, 1);
    check("es_epoch", epoch_cnt, 1);
    check("es_err", err_cnt, 0);
    check("es_weight", dp_weight, wplus(w1, SAMPLES));

    // 3 errors in epoch 1, clean epoch 2
    bad_limit = 3;
    run(w0, 0, 0, 3, cyc);
    check("ec_cycles", cyc, 1 + 2 * SAMPLES * PER_SMP);
    check("ec_conv", converged, 1);
    check("ec_epoch", epoch_cnt, 2);
    check("ec_err", err_cnt, 0);
    check("ec_weight", dp_weight, wplus(w0, 2 * SAMPLES));
`else
    // all-correct inferences still run every epoch
    bad_limit = 0;
    run(w1, 0, 0, -1, cyc);
    check("full_cycles", cyc, CYC_RUN);
    check("full_conv", converged, 0);
    check("full_epoch", epoch_cnt, EPOCHS);
`endif

    // reset in INFER discards the sample
    @(negedge clk);
    init_weight = w0; start = 1'b1; smp.smp_valid = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20 && dbg_state != S_INFER; k++) @(negedge clk);
    check("mid_in_infer", dbg_state, S_INFER);
    check("mid_weight_loaded", dp_weight, w0);
    reset = 1'b1;
    @(negedge clk);
    check("mid_state", dbg_state, S_IDLE);
    check("mid_weight", dp_weight, 0);
    check("mid_busy", busy, 0);
    check("mid_ready", smp.smp_ready, 0);
    check("mid_epoch", epoch_cnt, 0);
    reset = 1'b0;
    smp.smp_valid = 1'b0;
    repeat (INFER_LAT + 2) @(negedge clk);
    check("mid_no_commit", dp_weight, 0);
    check("mid_idle", dbg_state, S_IDLE);
    check("sb_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
